// File: rtl/mac_seq_ctrl.sv
// Sequencer for the 8-bit MAC datapath: clears the accumulator, streams LEN
// operand pairs in as one-cycle enables, waits out MAC latency, captures result.
module mac_seq_ctrl #(
  parameter int LEN_W   = 4,
  parameter int ACC_W   = 16,
  parameter int MAC_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a_in,
  input  logic [7:0]       b_in,
  output logic             mac_clr,
  output logic             mac_en,
  output logic [7:0]       mac_a,
  output logic [7:0]       mac_b,
  input  logic [ACC_W-1:0] mac_acc,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result
);
  localparam int DW = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN} state_e;

  state_e           state_q;
  logic [LEN_W-1:0] rem_q;
  logic [DW-1:0]    drain_q;
  logic             mac_clr_q, mac_en_q, busy_q, done_q;
  logic [7:0]       mac_a_q, mac_b_q;
  logic [ACC_W-1:0] result_q;
  logic             accept;

  // Abort wins over a same-edge handshake, so the pair is never taken.
  assign in_ready = (state_q == S_RUN) && ena;
  assign accept   = in_ready && in_valid && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      drain_q   <= '0;
      mac_clr_q <= 1'b0;
      mac_en_q  <= 1'b0;
      mac_a_q   <= '0;
      mac_b_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      mac_clr_q <= 1'b0;
      mac_en_q  <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ena && start) begin
            if (len != '0) begin
              rem_q   <= len;
              state_q <= S_CLEAR;
              busy_q  <= 1'b1;
            end else begin
              result_q <= '0;
              done_q   <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          // Clear is only issued on an enabled edge, so ena=0 defers it.
          if (ena) begin
            if (abort) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              mac_clr_q <= 1'b1;
              state_q   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (ena) begin
            if (abort) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else if (accept) begin
              mac_a_q  <= a_in;
              mac_b_q  <= b_in;
              mac_en_q <= 1'b1;
              rem_q    <= rem_q - LEN_W'(1);
              if (rem_q == LEN_W'(1)) begin
                state_q <= S_DRAIN;
                drain_q <= DW'(MAC_LAT);
              end
            end
          end
        end
        S_DRAIN: begin
          if (ena) begin
            if (abort) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else if (drain_q == '0) begin
              result_q <= mac_acc;
              done_q   <= 1'b1;
              state_q  <= S_IDLE;
              busy_q   <= 1'b0;
            end else begin
              drain_q <= drain_q - DW'(1);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mac_clr = mac_clr_q;
  assign mac_en  = mac_en_q;
  assign mac_a   = mac_a_q;
  assign mac_b   = mac_b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: directed scenarios plus randomized commands, checked
// against a MAC model and a sum-of-products reference for each command.
module tb_mac_seq_ctrl;
  localparam int LEN_W   = 4;
  localparam int ACC_W   = 16;
  localparam int MAC_LAT = 1;

  logic             clk = 1'b0;
  logic             rst_n, ena, start, abort, in_valid, in_ready;
  logic [LEN_W-1:0] len;
  logic [7:0]       a_in, b_in, mac_a, mac_b;
  logic             mac_clr, mac_en, busy, done;
  logic [ACC_W-1:0] mac_acc, result;

  int          n_chk = 0, n_err = 0;
  int          n_clr = 0, n_en = 0, n_done = 0;
  time         done_t = 0;
  logic [15:0] exp_result;
  logic [15:0] exp_q[$];
  logic [7:0]  pa[$], pb[$];
  logic [15:0] mon_p;

  mac_seq_ctrl #(.LEN_W(LEN_W), .ACC_W(ACC_W), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
    .mac_acc(mac_acc), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // MAC datapath model, one edge of latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       mac_acc <= '0;
    else if (mac_clr) mac_acc <= '0;
    else if (mac_en)  mac_acc <= mac_acc + 16'(mac_a) * 16'(mac_b);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every issued enable must carry the next pair the bench saw accepted.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mac_clr) n_clr++;
      if (mac_en) begin
        n_en++;
        chk("en_pending", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_p = exp_q.pop_front();
          chk("mac_a", mac_a, mon_p[15:8]);
          chk("mac_b", mac_b, mon_p[7:0]);
        end
      end
      if (done) begin
        n_done++;
        done_t = $time;
      end
    end
  end

  task automatic do_cmd(input int n, input int gap, input int frz_at, input int abort_after,
                        input bit bump, input bit rst_drain);
    int clr0, en0, dn0, acc_n, it, gap_left, frz_left, g;
    time t0, t_last;
    logic [15:0] sum;
    logic [7:0] a, b;
    bit rdy, aborted;
    clr0 = n_clr; en0 = n_en; dn0 = n_done;
    acc_n = 0; sum = '0; it = 0; gap_left = 0; frz_left = 0; aborted = 0; t_last = 0;
    a = '0; b = '0;
    @(posedge clk); #1;
    start = 1'b1; len = LEN_W'(n);
    @(posedge clk); t0 = $time; #1;
    start = 1'b0; len = LEN_W'($urandom_range(0, 15));
    if (n == 0) begin
      @(negedge clk);
      chk("z_done", done, 1);
      chk("z_result", result, 0);
      chk("z_busy", busy, 0);
      @(negedge clk); #1;
      chk("z_done_1cyc", done, 0);
      chk("z_clr_cnt", n_clr - clr0, 0);
      chk("z_en_cnt", n_en - en0, 0);
      exp_result = '0;
      return;
    end
    while (acc_n < n && it < 300) begin
      it++;
      abort = (abort_after >= 0 && acc_n == abort_after);
      if (it == frz_at) frz_left = 3;
      ena = (frz_left == 0);
      if (frz_left > 0) frz_left--;
      start = bump && (it == 4);
      if (gap_left > 0) begin
        in_valid = 1'b0;
        gap_left--;
      end else begin
        in_valid = 1'b1;
        a = (pa.size() != 0) ? pa[0] : 8'($urandom_range(0, 255));
        b = (pb.size() != 0) ? pb[0] : 8'($urandom_range(0, 255));
        a_in = a; b_in = b;
      end
      @(negedge clk);
      rdy = in_ready;
      if (!ena) chk("rdy_frozen", in_ready, 0);
      @(posedge clk);
      if (abort) aborted = 1;
      else if (in_valid && rdy) begin
        exp_q.push_back({a, b});
        sum = sum + 16'(a) * 16'(b);
        acc_n++;
        t_last = $time;
        gap_left = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        if (pa.size() != 0) begin
          void'(pa.pop_front());
          void'(pb.pop_front());
        end
      end
      #1;
      if (aborted) break;
    end
    in_valid = 1'b0; start = 1'b0; abort = 1'b0; ena = 1'b1;
    if (it >= 300) chk("accept_timeout", acc_n, n);
    if (aborted) begin
      @(negedge clk);
      chk("ab_busy", busy, 0);
      chk("ab_ready", in_ready, 0);
      repeat (6) @(negedge clk);
      #1;
      chk("ab_no_done", n_done - dn0, 0);
      chk("ab_result", result, exp_result);
      chk("ab_en_cnt", n_en - en0, acc_n);
      return;
    end
    if (rst_drain) begin
      #2; rst_n = 1'b0; #1;
      chk("rst_async", {busy, done, mac_en, mac_clr, in_ready, mac_a, mac_b, result}, 0);
      exp_q.delete();
      @(negedge clk); #1; rst_n = 1'b1;
      exp_result = '0;
      return;
    end
    @(negedge clk); #1;
    chk("drain_ready", in_ready, 0);
    chk("drain_busy", busy, 1);
    g = 0;
    while (n_done == dn0 && g < 20) begin
      @(negedge clk); #1;
      g++;
    end
    chk("done_seen", n_done - dn0, 1);
    chk("done_time", done_t, t_last + 64'((1 + MAC_LAT) * 10 + 5));
    if (gap == 0 && frz_at < 0) chk("latency", done_t, t0 + 64'((n + 3) * 10 + 5));
    chk("result", result, sum);
    chk("clr_cnt", n_clr - clr0, 1);
    chk("en_cnt", n_en - en0, n);
    @(negedge clk); #1;
    chk("done_1cyc", done, 0);
    chk("idle_busy", busy, 0);
    chk("done_cnt", n_done - dn0, 1);
    exp_result = sum;
  endtask

  initial begin
    logic [7:0] fa[3], fb[3];
    logic [15:0] r_ref;
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; len = '0; abort = 1'b0;
    in_valid = 1'b0; a_in = '0; b_in = '0; exp_result = '0;
    #3;
    chk("reset_outs", {busy, done, mac_en, mac_clr, in_ready, mac_a, mac_b, result}, 0);
    @(negedge clk); #1; rst_n = 1'b1;

    pa.push_back(8'd2);  pb.push_back(8'd3);
    pa.push_back(8'd4);  pb.push_back(8'd5);
    pa.push_back(8'd10); pb.push_back(8'd10);
    do_cmd(3, 0, -1, -1, 0, 0);
    chk("t_len3", result, 16'h007E);

    do_cmd(4, 0, -1, 2, 0, 0);
    chk("t_abort_keep", result, 16'h007E);

    pa.push_back(8'd255); pb.push_back(8'd255);
    pa.push_back(8'd255); pb.push_back(8'd255);
    do_cmd(2, 2, -1, -1, 0, 0);
    chk("t_gap", result, 16'hFC02);

    do_cmd(0, 0, -1, -1, 0, 0);
    chk("t_len0", result, 16'h0000);

    // Same pairs with and without an ena stall must give the same result.
    for (int i = 0; i < 3; i++) begin
      fa[i] = 8'($urandom_range(0, 255));
      fb[i] = 8'($urandom_range(0, 255));
      pa.push_back(fa[i]); pb.push_back(fb[i]);
    end
    do_cmd(3, 0, -1, -1, 0, 0);
    r_ref = result;
    for (int i = 0; i < 3; i++) begin
      pa.push_back(fa[i]); pb.push_back(fb[i]);
    end
    do_cmd(3, 0, 3, -1, 1, 0);
    chk("t_freeze_same", result, r_ref);

    for (int r = 0; r < 12; r++) begin
      int n, ab, fz;
      n  = $urandom_range(1, 15);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      fz = (ab < 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(3, 8)) : -1;
      do_cmd(n, -1, fz, ab, 1'($urandom_range(0, 1)), 0);
    end

    do_cmd(3, -1, -1, -1, 0, 1);
    pa.push_back(8'd7); pb.push_back(8'd9);
    do_cmd(1, 0, -1, -1, 0, 0);
    chk("t_after_reset", result, 16'h003F);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
    $fatal(1);
  end

endmodule
